// File: rtl/updn_ctr_sequencer_pkg.sv
// Shared types for the up/down counter sweep sequencer: FSM states, default
// field widths and the captured command record.
package updn_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 8;
  localparam int REP_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN,
    DONE
  } state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] start;
    logic [LEN_W_DEF-1:0] up_len;
    logic [LEN_W_DEF-1:0] dn_len;
    logic [REP_W_DEF-1:0] reps;
  } cmd_t;

  // A repeat count of zero still runs one pass.
  function automatic logic [REP_W_DEF-1:0] eff_reps(input logic [REP_W_DEF-1:0] r);
    return (r == '0) ? REP_W_DEF'(1) : r;
  endfunction

endpackage

// File: rtl/updn_ctr_sequencer_if.sv
// Command handshake bundle between the control register block (master) and
// the sweep sequencer (slave).
interface updn_ctr_sequencer_if
  import updn_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int REP_W = REP_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [LEN_W-1:0] cmd_up_len;
  logic [LEN_W-1:0] cmd_dn_len;
  logic [REP_W-1:0] cmd_reps;

  modport master (
    output cmd_valid, cmd_start, cmd_up_len, cmd_dn_len, cmd_reps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_up_len, cmd_dn_len, cmd_reps,
    output cmd_ready
  );
endinterface

// File: rtl/updn_ctr_sequencer_phase_cnt.sv
// Loadable phase-length down-counter; last_o flags the final cycle of a phase.
module updn_seq_phase_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/updn_ctr_sequencer.sv
// Drives a DW03_updn_ctr through load / up / down sweeps with repeat.
// Optional macro UPDN_SEQ_TERCNT_STOP_EN: stop on tercnt and flag wrap_stop.
module updn_ctr_sequencer
  import updn_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  updn_ctr_sequencer_if.slave   cmd,
  input  logic                  abort,
  output logic [WIDTH-1:0]      ctr_data,
  output logic                  ctr_load_n,
  output logic                  ctr_cen,
  output logic                  ctr_up_dn,
  input  logic                  ctr_tercnt,
  input  logic [WIDTH-1:0]      ctr_count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
`ifdef UPDN_SEQ_TERCNT_STOP_EN
  ,
  output logic                  wrap_stop
`endif
);

  state_e           state_q, state_d;
  cmd_t             cmd_q;
  logic [REP_W-1:0] reps_left_q, reps_left_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] ctr_data_q, ctr_data_d;
  logic             ctr_load_n_q, ctr_load_n_d;
  logic             ctr_up_dn_q, ctr_up_dn_d;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
  logic             wrap_q, wrap_d;
`endif

  logic             accept;
  logic             in_run;
  logic             stop_tc;
  logic             phase_last;
  logic             phase_end;
  logic             phase_load;
  logic [LEN_W-1:0] phase_val;
  state_e           restart;
  logic             unused_status;

  assign accept = cmd.cmd_valid & cmd.cmd_ready;
  assign in_run = (state_q == UP) || (state_q == DOWN);

`ifdef UPDN_SEQ_TERCNT_STOP_EN
  assign stop_tc = in_run & ctr_tercnt;
`else
  assign stop_tc = 1'b0;
`endif

  // Abort and terminal-count stop must suppress the count on this very edge.
  assign ctr_cen   = in_run & ~abort & ~stop_tc;
  assign phase_end = ctr_cen & phase_last;
  assign restart   = (cmd_q.up_len == '0) ? DOWN : UP;
  assign phase_val = (state_d == DOWN) ? cmd_q.dn_len : cmd_q.up_len;

  updn_seq_phase_cnt #(
    .LEN_W(LEN_W)
  ) u_phase_cnt (
    .clk       (clk),
    .rst_i     (reset),
    .load_i    (phase_load),
    .load_val_i(phase_val),
    .dec_i     (ctr_cen),
    .last_o    (phase_last)
  );

  always_comb begin
    state_d     = state_q;
    reps_left_d = reps_left_q;
    aborted_d   = aborted_q;
    phase_load  = 1'b0;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
    wrap_d      = wrap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = LOAD;
          aborted_d = 1'b0;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
          wrap_d    = 1'b0;
`endif
        end
      end
      LOAD: begin
        reps_left_d = eff_reps(cmd_q.reps);
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (cmd_q.up_len != '0) begin
          state_d    = UP;
          phase_load = 1'b1;
        end else if (cmd_q.dn_len != '0) begin
          state_d    = DOWN;
          phase_load = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      UP, DOWN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (stop_tc) begin
          state_d = DONE;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
          wrap_d  = 1'b1;
`endif
        end else if (phase_end) begin
          if ((state_q == UP) && (cmd_q.dn_len != '0)) begin
            state_d    = DOWN;
            phase_load = 1'b1;
          end else if (reps_left_q == REP_W'(1)) begin
            state_d = DONE;
          end else begin
            reps_left_d = reps_left_q - REP_W'(1);
            state_d     = restart;
            phase_load  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are registered so they line up with the state they serve.
  always_comb begin
    ctr_data_d   = accept ? cmd.cmd_start : ctr_data_q;
    ctr_load_n_d = (state_d != LOAD);
    ctr_up_dn_d  = (state_d != DOWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      reps_left_q  <= '0;
      aborted_q    <= 1'b0;
      ctr_data_q   <= '0;
      ctr_load_n_q <= 1'b1;
      ctr_up_dn_q  <= 1'b1;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
      wrap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      reps_left_q  <= reps_left_d;
      aborted_q    <= aborted_d;
      ctr_data_q   <= ctr_data_d;
      ctr_load_n_q <= ctr_load_n_d;
      ctr_up_dn_q  <= ctr_up_dn_d;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
      wrap_q       <= wrap_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= '{start:  cmd.cmd_start,
                 up_len: cmd.cmd_up_len,
                 dn_len: cmd.cmd_dn_len,
                 reps:   cmd.cmd_reps};
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign aborted       = aborted_q;
  assign ctr_data      = ctr_data_q;
  assign ctr_load_n    = ctr_load_n_q;
  assign ctr_up_dn     = ctr_up_dn_q;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
  assign wrap_stop     = wrap_q;
`endif

  // Count value is observed by software elsewhere; tercnt only matters with the stop option.
  assign unused_status = ^{ctr_count, ctr_tercnt};

endmodule

// File: tb/tb_updn_ctr_sequencer.sv
// Directed bench for updn_ctr_sequencer with a behavioural up/down counter
// standing in for the DW03_updn_ctr instance.
module tb_updn_ctr_sequencer;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] ctr_data;
  logic             ctr_load_n, ctr_cen, ctr_up_dn, ctr_tercnt;
  logic [WIDTH-1:0] ctr_count;
  logic             busy, done, aborted;
`ifdef UPDN_SEQ_TERCNT_STOP_EN
  logic             wrap_stop;
`endif

  logic [WIDTH-1:0] cnt = '0;
  int               n_chk = 0;
  int               n_pass = 0;
  int               seq[$];
  int               e[$];
  int               cen_cnt = 0;
  int               done_cnt = 0;
  logic             mon_clr = 1'b0;

  updn_ctr_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) cif ();

  always #5 clk = ~clk;

  updn_ctr_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cif),
    .abort     (abort),
    .ctr_data  (ctr_data),
    .ctr_load_n(ctr_load_n),
    .ctr_cen   (ctr_cen),
    .ctr_up_dn (ctr_up_dn),
    .ctr_tercnt(ctr_tercnt),
    .ctr_count (ctr_count),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
`ifdef UPDN_SEQ_TERCNT_STOP_EN
    ,
    .wrap_stop (wrap_stop)
`endif
  );

  // Counter model: synchronous active-low load, enable, up/down, tercnt at the end value.
  always @(posedge clk) begin
    if (!ctr_load_n)  cnt <= ctr_data;
    else if (ctr_cen) cnt <= ctr_up_dn ? 4'(cnt + 4'd1) : 4'(cnt - 4'd1);
  end
  assign ctr_count  = cnt;
  assign ctr_tercnt = ctr_up_dn ? (cnt == 4'hF) : (cnt == 4'h0);

  // Record every value the counter takes on, plus enable and done activity.
  always @(posedge clk) begin
    if (mon_clr) begin
      seq.delete();
      cen_cnt  = 0;
      done_cnt = 0;
    end else begin
      if (!ctr_load_n)  seq.push_back(int'(ctr_data));
      else if (ctr_cen) seq.push_back(ctr_up_dn ? int'(4'(cnt + 4'd1)) : int'(4'(cnt - 4'd1)));
      if (ctr_cen) cen_cnt++;
      if (done)    done_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_seq(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, seq.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_%0d", tag, i), (i < seq.size()) ? seq[i] : -1, exp_q[i]);
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic set_cmd(input int s, input int u, input int d, input int r);
    cif.cmd_start  = 4'(s);
    cif.cmd_up_len = 8'(u);
    cif.cmd_dn_len = 8'(d);
    cif.cmd_reps   = 4'(r);
  endtask

  // Returns one time step after the accepting edge.
  task automatic send(input int s, input int u, input int d, input int r);
    @(posedge clk); #1;
    set_cmd(s, u, d, r);
    cif.cmd_valid = 1'b1;
    @(posedge clk); #1 cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 200);
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_ready", int'(cif.cmd_ready), 1);
    chk("rst_data", int'(ctr_data), 0);
    chk("rst_load_n", int'(ctr_load_n), 1);
    chk("rst_cen", int'(ctr_cen), 0);
    chk("rst_up_dn", int'(ctr_up_dn), 1);
    @(posedge clk); #1 reset = 1'b0;

    // Triangle sweep, two passes
    clear_mon();
    send(7, 3, 5, 2);
    wait_idle("t1_idle");
    e = '{7, 8, 9, 10, 9, 8, 7, 6, 5, 6, 7, 8, 7, 6, 5, 4, 3};
    chk_seq("t1_seq", e);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_cen_cnt", cen_cnt, 16);
    chk("t1_final", int'(cnt), 3);

    // Count up across the wrap point
    clear_mon();
    send(14, 3, 0, 1);
    wait_idle("t2_idle");
    chk("t2_done_cnt", done_cnt, 1);
`ifdef UPDN_SEQ_TERCNT_STOP_EN
    e = '{14, 15};
    chk_seq("t2_seq", e);
    chk("t2_final", int'(cnt), 15);
    chk("t2_wrap_stop", int'(wrap_stop), 1);
`else
    e = '{14, 15, 0, 1};
    chk_seq("t2_seq", e);
    chk("t2_final", int'(cnt), 1);
`endif

    // Abort on the 4th UP cycle
    clear_mon();
    send(2, 10, 0, 1);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("t3_busy_at_abort", int'(busy), 1);
    chk("t3_cen_gated", int'(ctr_cen), 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t3_aborted", int'(aborted), 1);
    chk("t3_ready", int'(cif.cmd_ready), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_done_cnt", done_cnt, 0);
    e = '{2, 3, 4, 5};
    chk_seq("t3_seq", e);
    chk("t3_final", int'(cnt), 5);
`ifdef UPDN_SEQ_TERCNT_STOP_EN
    chk("t3_wrap_clr", int'(wrap_stop), 0);
`endif

    // Zero-length phases: load then done
    clear_mon();
    send(9, 0, 0, 1);
    @(negedge clk);
    chk("t4_aborted_clr", int'(aborted), 0);
    chk("t4_load_n", int'(ctr_load_n), 0);
    chk("t4_done_early", int'(done), 0);
    @(negedge clk);
    chk("t4_done", int'(done), 1);
    chk("t4_count", int'(cnt), 9);
    @(negedge clk);
    chk("t4_done_off", int'(done), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_cen_cnt", cen_cnt, 0);
    chk("t4_done_cnt", done_cnt, 1);
    e = '{9};
    chk_seq("t4_seq", e);

    // Reset in DOWN with a new command held through reset
    clear_mon();
    send(7, 3, 5, 2);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    set_cmd(4, 1, 0, 1);
    cif.cmd_valid = 1'b1;
    @(negedge clk);
    chk("t5_busy_pre", int'(busy), 1);
    chk("t5_up_dn_pre", int'(ctr_up_dn), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_aborted", int'(aborted), 0);
    chk("t5_ready", int'(cif.cmd_ready), 1);
    chk("t5_data", int'(ctr_data), 0);
    chk("t5_load_n", int'(ctr_load_n), 1);
    chk("t5_cen", int'(ctr_cen), 0);
    chk("t5_up_dn", int'(ctr_up_dn), 1);
    chk("t5_count_kept", int'(cnt), 8);
    @(posedge clk); #1 cif.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_accepted", int'(busy), 1);
    chk("t5_load2_n", int'(ctr_load_n), 0);
    chk("t5_data2", int'(ctr_data), 4);
    wait_idle("t5_idle");
    chk("t5_final", int'(cnt), 5);
    chk("t5_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/updn_ctr_sequencer.md
Name: updn_ctr_sequencer

Overview:
- Sequencer that drives one DW03_updn_ctr instance through a programmed sweep: load a start value, count up N cycles, count down M cycles, repeat R times.
- Sits between the control register block (command handshake) and the counter's data/load/cen/up_dn pins.
- Monitors the counter's tercnt and count outputs.
- Lets software run triangle/sawtooth sweeps without cycle-accurate pin control.

Parameters:
- WIDTH, 4, counter data/count width; must match the counter instance.
- LEN_W, 8, width of the up/down phase length fields.
- REP_W, 4, width of the repeat-count field.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_up_len  in  LEN_W  up-count cycles per pass.
- cmd_dn_len  in  LEN_W  down-count cycles per pass.
- cmd_reps  in  REP_W  number of passes; 0 is treated as 1.
- abort  in  1  synchronous abort of a running sweep.
- ctr_data  out  WIDTH  to counter data.
- ctr_load_n  out  1  to counter load (active low).
- ctr_cen  out  1  to counter cen.
- ctr_up_dn  out  1  to counter up_dn (1 = up).
- ctr_tercnt  in  1  from counter tercnt.
- ctr_count  in  WIDTH  from counter count (status only).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- aborted  out  1  sticky flag; cleared by the next accepted command.

Behaviour:
- Reset outputs:
  - State = IDLE.
  - ctr_data = 0, ctr_load_n = 1, ctr_cen = 0, ctr_up_dn = 1.
  - busy = 0, done = 0, aborted = 0, cmd_ready = 1.
- Reset mid-sweep: returns to IDLE at the next edge; the counter value is left untouched.
- Handshake:
  - A command is accepted on the edge where cmd_valid & cmd_ready are both high.
  - All cmd_* fields are captured into internal registers at acceptance.
  - cmd_valid is ignored while busy.
- States: IDLE, LOAD, UP, DOWN, DONE.
  - IDLE -> LOAD on acceptance.
  - LOAD: exactly one cycle. ctr_load_n = 0 and ctr_data = start; the counter holds start after that edge. Then go to UP, or to DOWN if up_len = 0.
  - UP: ctr_cen = 1, ctr_up_dn = 1 for exactly up_len cycles. Then go to DOWN, or skip DOWN if dn_len = 0.
  - DOWN: ctr_cen = 1, ctr_up_dn = 0 for exactly dn_len cycles.
  - End of a pass: decrement the remaining-pass count. If passes remain, go to UP (no reload); otherwise go to DONE.
  - If up_len = dn_len = 0, go LOAD -> DONE directly.
  - DONE: one cycle. done = 1, then IDLE.
- Abort:
  - Sampled in LOAD, UP and DOWN.
  - ctr_cen is forced to 0 in the same cycle (combinational gate), so no count occurs on that edge.
  - Next state is IDLE; aborted is set; done does not pulse.
  - abort in IDLE or DONE is ignored.
  - If abort arrives in the same cycle as a phase end, abort wins.
- ctr_cen: decoded from registered state. ctr_load_n, ctr_up_dn and ctr_data are registered.
- Counter wrap-around (15 -> 0, 0 -> 15) is allowed and not flagged unless the optional feature is compiled in.
- Phase counters: LEN_W-bit down-counters loaded with the phase length on phase entry. Phase ends when the counter is 1 and cen is active.

Optional Feature:
- Macro: UPDN_SEQ_TERCNT_STOP_EN.
- With the macro defined:
  - In UP or DOWN, ctr_tercnt = 1 combinationally gates ctr_cen to 0, so the counter holds at its terminal value.
  - The FSM goes to DONE, pulses done, and sets a sticky port wrap_stop (out, 1), cleared on the next accepted command.
- Without the macro: tercnt is ignored, the counter wraps freely, and the wrap_stop port does not exist.

Decomposition:
- Package updn_seq_pkg holds:
  - state enum (IDLE, LOAD, UP, DOWN, DONE);
  - LEN_W/REP_W defaults;
  - the command struct {start, up_len, dn_len, reps}.
- One sub-module, updn_seq_phase_cnt: loadable down-counter with a terminal flag, used for the phase length.
- Pass counting stays inline in the top level.

Test Plan:
- WIDTH = 4, start = 7, up = 3, dn = 5, reps = 2:
  - count sequence 7, 8, 9, 10, 9, 8, 7, 6, 5, 6, 7, 8, 7, 6, 5, 4, 3;
  - done pulses once; 16 cen-high cycles in total.
- start = 14, up = 3, dn = 0, reps = 1, macro off: count 14, 15, 0, 1; done, wrap_stop absent.
- Same stimulus, macro on: count 14, 15, then holds 15; done = 1, wrap_stop = 1.
- start = 2, up = 10, abort asserted on the 4th UP cycle: count stops at 5; aborted = 1; done = 0; cmd_ready = 1 the next cycle.
- up = dn = 0, start = 9: one load, count = 9, done two cycles after acceptance, zero cen cycles.
- Reset asserted mid-DOWN:
  - next cycle all outputs at reset values;
  - a cmd_valid held through reset is accepted on the first cycle after reset deasserts.
